polygon_hit_tester: RTL and testbench

//  Multi-polygon point-in-polygon tester; successor to the angle-sum in-polygon block.

---
 rtl/polygon_pkg.sv | 52 +++++
 rtl/edge_crossing.sv | 52 +++++
 rtl/polygon_hit_tester.sv | 180 ++++++++++++++++++
 tb/tb_polygon_hit_tester.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/polygon_pkg.sv
// Shared types, sizes and the edge cross-product helper for the polygon hit tester.
package polygon_pkg;

   localparam int PIXEL_WIDTH      = 1280;
   localparam int PIXEL_HEIGHT     = 720;
   localparam int MAX_NUM_VERTICES = 32;
   localparam int NUM_POLYGONS     = 4;
   localparam int COORD_WIDTH      = 16;

   localparam int VW          = $clog2(MAX_NUM_VERTICES);
   localparam int PW          = $clog2(NUM_POLYGONS);
   localparam int HW          = $clog2(PIXEL_WIDTH);
   localparam int VCW         = $clog2(PIXEL_HEIGHT);
   localparam int CROSS_WIDTH = 2 * COORD_WIDTH + 2;

   typedef logic signed [COORD_WIDTH-1:0] coord_t;
   typedef logic signed [CROSS_WIDTH-1:0] cross_t;
   typedef logic signed [VW+1:0]          wind_t;
   typedef logic        [VW:0]            count_t;
   typedef logic        [VW-1:0]          vidx_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } vertex_t;

   typedef enum logic {
      FILL_EVEN_ODD = 1'b0,
      FILL_NONZERO  = 1'b1
   } fill_rule_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_RESULT
   } state_t;

   // Which side of edge vi->vj the point lies on: (xj-xi)*(py-yi) - (px-xi)*(yj-yi).
   function automatic cross_t edge_cross(input vertex_t vi, input vertex_t vj, input vertex_t pt);
      cross_t dx_e;
      cross_t dy_e;
      cross_t dx_p;
      cross_t dy_p;
      dx_e = cross_t'(vj.x) - cross_t'(vi.x);
      dy_e = cross_t'(vj.y) - cross_t'(vi.y);
      dx_p = cross_t'(pt.x) - cross_t'(vi.x);
      dy_p = cross_t'(pt.y) - cross_t'(vi.y);
      return (dx_e * dy_p) - (dx_p * dy_e);
   endfunction

endpackage

// File: rtl/edge_crossing.sv
// One-edge crossing test: half-open up/down classification plus registered cross-product sign.
module edge_crossing
   import polygon_pkg::*;
(
   input  logic    clk_i,
   input  logic    rst_n_i,
   input  logic    en_i,
   input  vertex_t vi_i,
   input  vertex_t vj_i,
   input  vertex_t pt_i,
   output logic    up_o,
   output logic    down_o,
   output logic    cr_pos_o,
   output logic    cr_neg_o
);

   cross_t cr;
   logic   up_d, down_d, cr_pos_d, cr_neg_d;
   logic   up_q, down_q, cr_pos_q, cr_neg_q;

   // Classify the edge against the point's scanline; disabled edges never report a crossing.
   // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
   always_comb begin
      cr       = edge_cross(vi_i, vj_i, pt_i);
      up_d     = en_i & (vi_i.y <= pt_i.y) & (vj_i.y > pt_i.y);
      down_d   = en_i & (vi_i.y > pt_i.y) & (vj_i.y <= pt_i.y);
      cr_pos_d = (cr > cross_t'(0));
      cr_neg_d = (cr < cross_t'(0));
   end

   // Product stage register: one cycle from edge presented to classification available.
   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         cr_pos_q <= 1'b0;
         cr_neg_q <= 1'b0;
      end else begin
         up_q     <= up_d;
         down_q   <= down_d;
         cr_pos_q <= cr_pos_d;
         cr_neg_q <= cr_neg_d;
      end
   end

   assign up_o     = up_q;
   assign down_o   = down_q;
   assign cr_pos_o = cr_pos_q;
   assign cr_neg_o = cr_neg_q;

endmodule

// File: rtl/polygon_hit_tester.sv
// Multi-polygon point-in-polygon tester: scans one edge per cycle for all polygons in
// parallel and reports a per-polygon inside mask under even-odd or nonzero fill.
module polygon_hit_tester
   import polygon_pkg::*;
(
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          cfg_we_in,
   input  logic [PW-1:0]                 cfg_poly_in,
   input  logic [VW-1:0]                 cfg_idx_in,
   input  logic signed [COORD_WIDTH-1:0] cfg_x_in,
   input  logic signed [COORD_WIDTH-1:0] cfg_y_in,
   input  logic                          cfg_cnt_we_in,
   input  logic [VW:0]                   cfg_cnt_in,
   output logic                          cfg_ready_out,
   input  logic                          nonzero_in,
   input  logic                          pt_valid_in,
   input  logic [HW-1:0]                 hcount_in,
   input  logic [VCW-1:0]                vcount_in,
   output logic                          pt_ready_out,
   output logic                          res_valid_out,
   input  logic                          res_ready_in,
   output logic [NUM_POLYGONS-1:0]       inside_out
);

   state_t                  state_q;
   vidx_t                   k_q;
   vertex_t                 pt_q;
   fill_rule_t              mode_q;
   logic                    vld_q;
   logic                    cfg_ready_q;
   logic                    pt_ready_q;
   logic                    res_valid_q;
   logic [NUM_POLYGONS-1:0] inside_q;
   logic [NUM_POLYGONS-1:0] inside_d;

   vertex_t                 vert_q    [NUM_POLYGONS][MAX_NUM_VERTICES];
   count_t                  num_pts_q [NUM_POLYGONS];

   wind_t                   wind_q    [NUM_POLYGONS];
   wind_t                   wind_d    [NUM_POLYGONS];
   logic [NUM_POLYGONS-1:0] parity_q;
   logic [NUM_POLYGONS-1:0] parity_d;

   logic [NUM_POLYGONS-1:0] up_w, down_w, cr_pos_w, cr_neg_w;

   logic accept;
   logic cfg_open;

   assign accept   = pt_valid_in & pt_ready_q;
   assign cfg_open = (state_q == ST_IDLE);

   // Vertex storage, written only while idle so a scan always sees a frozen polygon set.
   // NOTE: vertex storage has no reset; stale entries are harmless because edges at or past num_points are disabled.
   always_ff @(posedge clk_in) begin
      if (cfg_we_in && cfg_open) begin
         vert_q[cfg_poly_in][cfg_idx_in] <= '{x: cfg_x_in, y: cfg_y_in};
      end
   end

   // Per-polygon vertex counts; cleared on reset so every polygon starts empty.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int p = 0; p < NUM_POLYGONS; p++) num_pts_q[p] <= '0;
      end else if (cfg_cnt_we_in && cfg_open) begin
         num_pts_q[cfg_poly_in] <= cfg_cnt_in;
      end
   end

   for (genvar p = 0; p < NUM_POLYGONS; p++) begin : g_poly
      logic  en;
      vidx_t j_idx;

      // Edge k closes back to vertex 0 on the last vertex; edges past the count are disabled.
      always_comb begin
         en    = (state_q == ST_SCAN) && ({1'b0, k_q} < num_pts_q[p]);
         j_idx = (({1'b0, k_q} + count_t'(1)) == num_pts_q[p]) ? '0 : k_q + vidx_t'(1);
      end

      edge_crossing u_edge (
         .clk_i    (clk_in),
         .rst_n_i  (rst_n_in),
         .en_i     (en),
         .vi_i     (vert_q[p][k_q]),
         .vj_i     (vert_q[p][j_idx]),
         .pt_i     (pt_q),
         .up_o     (up_w[p]),
         .down_o   (down_w[p]),
         .cr_pos_o (cr_pos_w[p]),
         .cr_neg_o (cr_neg_w[p])
      );
   end

   // Next winding/parity from the registered edge result, and the mask that would result from it.
   always_comb begin
      parity_d = parity_q;
      inside_d = '0;
      for (int p = 0; p < NUM_POLYGONS; p++) begin
         wind_d[p] = wind_q[p];
         if (vld_q && up_w[p] && cr_pos_w[p]) begin
            wind_d[p]   = wind_q[p] + wind_t'(1);
            parity_d[p] = ~parity_q[p];
         end else if (vld_q && down_w[p] && cr_neg_w[p]) begin
            wind_d[p]   = wind_q[p] - wind_t'(1);
            parity_d[p] = ~parity_q[p];
         end
         if (num_pts_q[p] >= count_t'(3)) begin
            inside_d[p] = (mode_q == FILL_NONZERO) ? (wind_d[p] != '0) : parity_d[p];
         end
      end
   end

   // Accumulators: cleared when a query is accepted, otherwise integrate each edge result.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int p = 0; p < NUM_POLYGONS; p++) wind_q[p] <= '0;
         parity_q <= '0;
      end else if (accept) begin
         for (int p = 0; p < NUM_POLYGONS; p++) wind_q[p] <= '0;
         parity_q <= '0;
      end else begin
         wind_q   <= wind_d;
         parity_q <= parity_d;
      end
   end

   // Query FSM with edge counter and registered handshake/result outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         pt_q        <= '0;
         mode_q      <= FILL_EVEN_ODD;
         vld_q       <= 1'b0;
         cfg_ready_q <= 1'b1;
         pt_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         inside_q    <= '0;
      end else begin
         // The edge stage output is meaningful one cycle after each SCAN cycle.
         vld_q <= (state_q == ST_SCAN);
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  pt_q        <= '{x: coord_t'(hcount_in), y: coord_t'(vcount_in)};
                  mode_q      <= fill_rule_t'(nonzero_in);
                  k_q         <= '0;
                  pt_ready_q  <= 1'b0;
                  cfg_ready_q <= 1'b0;
                  state_q     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               k_q <= k_q + vidx_t'(1);
               if (k_q == vidx_t'(MAX_NUM_VERTICES - 1)) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               inside_q    <= inside_d;
               res_valid_q <= 1'b1;
               state_q     <= ST_RESULT;
            end
            ST_RESULT: begin
               if (res_ready_in) begin
                  res_valid_q <= 1'b0;
                  pt_ready_q  <= 1'b1;
                  cfg_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg_ready_out = cfg_ready_q;
   assign pt_ready_out  = pt_ready_q;
   assign res_valid_out = res_valid_q;
   assign inside_out    = inside_q;

endmodule

// File: tb/tb_polygon_hit_tester.sv
// Scoreboard bench for polygon_hit_tester: queries push expected masks, a monitor pops
// and compares whenever a result is handed over.
module tb_polygon_hit_tester;
   import polygon_pkg::*;

   logic                          clk_in = 1'b0;
   logic                          rst_n_in = 1'b1;
   logic                          cfg_we_in = 1'b0;
   logic [PW-1:0]                 cfg_poly_in = '0;
   logic [VW-1:0]                 cfg_idx_in = '0;
   logic signed [COORD_WIDTH-1:0] cfg_x_in = '0;
   logic signed [COORD_WIDTH-1:0] cfg_y_in = '0;
   logic                          cfg_cnt_we_in = 1'b0;
   logic [VW:0]                   cfg_cnt_in = '0;
   logic                          cfg_ready_out;
   logic                          nonzero_in = 1'b0;
   logic                          pt_valid_in = 1'b0;
   logic [HW-1:0]                 hcount_in = '0;
   logic [VCW-1:0]                vcount_in = '0;
   logic                          pt_ready_out;
   logic                          res_valid_out;
   logic                          res_ready_in = 1'b1;
   logic [NUM_POLYGONS-1:0]       inside_out;

   polygon_hit_tester dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .cfg_we_in     (cfg_we_in),
      .cfg_poly_in   (cfg_poly_in),
      .cfg_idx_in    (cfg_idx_in),
      .cfg_x_in      (cfg_x_in),
      .cfg_y_in      (cfg_y_in),
      .cfg_cnt_we_in (cfg_cnt_we_in),
      .cfg_cnt_in    (cfg_cnt_in),
      .cfg_ready_out (cfg_ready_out),
      .nonzero_in    (nonzero_in),
      .pt_valid_in   (pt_valid_in),
      .hcount_in     (hcount_in),
      .vcount_in     (vcount_in),
      .pt_ready_out  (pt_ready_out),
      .res_valid_out (res_valid_out),
      .res_ready_in  (res_ready_in),
      .inside_out    (inside_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [NUM_POLYGONS-1:0] mask;
      string                   name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Square (100,100)(200,100)(200,200)(100,200) and a five-point star around (300,300).
   int sq_x[4]   = '{100, 200, 200, 100};
   int sq_y[4]   = '{100, 100, 200, 200};
   int star_x[5] = '{300, 359, 205, 395, 241};
   int star_y[5] = '{200, 381, 269, 269, 381};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a result is consumed on the next rising edge whenever valid and ready are both high.
   always @(negedge clk_in) begin
      if (rst_n_in && res_valid_out === 1'b1 && res_ready_in === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, 64'(inside_out), 64'(mon_e.mask));
         end
      end
   end

   task automatic cfg_vertex(input int p, input int i, input int x, input int y);
      cfg_poly_in = p[PW-1:0];
      cfg_idx_in  = i[VW-1:0];
      cfg_x_in    = x[COORD_WIDTH-1:0];
      cfg_y_in    = y[COORD_WIDTH-1:0];
      cfg_we_in   = 1'b1;
      @(posedge clk_in);
      #1;
      cfg_we_in   = 1'b0;
   endtask

   task automatic cfg_count(input int p, input int n);
      cfg_poly_in   = p[PW-1:0];
      cfg_cnt_in    = n[VW:0];
      cfg_cnt_we_in = 1'b1;
      @(posedge clk_in);
      #1;
      cfg_cnt_we_in = 1'b0;
   endtask

   // Issue one query, check its latency, optionally stall the result for 'hold' cycles.
   task automatic query(input int h, input int v, input bit nz, input logic [NUM_POLYGONS-1:0] mask,
                        input string name, input int hold);
      int                      waited;
      int                      lat;
      int                      bad;
      logic [NUM_POLYGONS-1:0] snap;
      exp_t                    e;
      e.mask = mask;
      e.name = name;
      sb_q.push_back(e);
      hcount_in    = h[HW-1:0];
      vcount_in    = v[VCW-1:0];
      nonzero_in   = nz;
      res_ready_in = (hold == 0);
      pt_valid_in  = 1'b1;
      waited = 0;
      do begin
         @(negedge clk_in);
         waited++;
      end while (pt_ready_out !== 1'b1 && waited < 100);
      if (pt_ready_out !== 1'b1) begin
         check({name, "_accept_timeout"}, 64'd0, 64'd1);
         pt_valid_in = 1'b0;
         return;
      end
      @(posedge clk_in);
      #1;
      pt_valid_in = 1'b0;
      lat = 0;
      do begin
         @(negedge clk_in);
         lat++;
      end while (res_valid_out !== 1'b1 && lat < 100);
      check({name, "_latency"}, 64'(lat), 64'(MAX_NUM_VERTICES + 2));
      if (hold > 0) begin
         snap = inside_out;
         bad  = 0;
         repeat (hold) begin
            @(posedge clk_in);
            #1;
            if (res_valid_out !== 1'b1 || inside_out !== snap || pt_ready_out !== 1'b0) bad++;
         end
         check({name, "_hold_unstable_cycles"}, 64'(bad), 64'd0);
         res_ready_in = 1'b1;
      end
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      int waited;
      #3 rst_n_in = 1'b0;
      #9;
      check("reset_res_valid", 64'(res_valid_out), 64'd0);
      check("reset_inside", 64'(inside_out), 64'd0);
      check("reset_pt_ready", 64'(pt_ready_out), 64'd1);
      check("reset_cfg_ready", 64'(cfg_ready_out), 64'd1);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;

      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 4; i++) cfg_vertex(p, i, sq_x[i], sq_y[i]);
      for (int i = 0; i < 5; i++) cfg_vertex(3, i, star_x[i], star_y[i]);
      cfg_count(0, 4);
      cfg_count(1, 2);
      cfg_count(2, 0);
      cfg_count(3, 5);

      query(150, 150, 1'b0, 4'b0001, "square_centre", 0);
      query(50,  150, 1'b0, 4'b0000, "square_left",   0);
      query(250, 150, 1'b1, 4'b0000, "square_right",  0);
      query(300, 300, 1'b0, 4'b0000, "star_centre_evenodd", 0);
      query(300, 300, 1'b1, 4'b1000, "star_centre_nonzero", 0);
      query(300, 220, 1'b0, 4'b1000, "star_tip_evenodd",    0);
      query(300, 220, 1'b1, 4'b1000, "star_tip_nonzero",    0);
      query(150, 150, 1'b1, 4'b0001, "square_backpressure", 10);

      fork
         query(150, 150, 1'b0, 4'b0001, "cfg_during_scan", 0);
         begin
            repeat (8) @(posedge clk_in);
            #1;
            check("cfg_ready_during_scan", 64'(cfg_ready_out), 64'd0);
            cfg_vertex(0, 1, 1000, 1000);
            cfg_count(0, 0);
         end
      join
      query(150, 150, 1'b0, 4'b0001, "after_dropped_cfg", 0);

      hcount_in   = 11'd150;
      vcount_in   = 10'd150;
      nonzero_in  = 1'b1;
      pt_valid_in = 1'b1;
      waited = 0;
      do begin
         @(negedge clk_in);
         waited++;
      end while (pt_ready_out !== 1'b1 && waited < 100);
      @(posedge clk_in);
      #1;
      pt_valid_in = 1'b0;
      repeat (10) @(posedge clk_in);
      #1;
      rst_n_in = 1'b0;
      #1;
      check("abort_res_valid", 64'(res_valid_out), 64'd0);
      check("abort_inside", 64'(inside_out), 64'd0);
      check("abort_pt_ready", 64'(pt_ready_out), 64'd1);
      check("abort_cfg_ready", 64'(cfg_ready_out), 64'd1);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in);
      #1;
      query(150, 150, 1'b1, 4'b0000, "after_reset_counts_cleared", 0);

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
